// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART programming-link receiver.
// Receives serial bytes on rx_i, packs four of them little-endian into a
// 32-bit word and writes each word to instruction memory at incrementing
// word addresses. Loading ends on the terminator word or when MAX_WORDS
// words have been written; prog_done then stays high until reset.
// Optional feature macro: UART_PARITY_EN (8E1 framing with an even-parity
// check). When it is undefined, the framing is 8N1 and there is no parity logic.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 12,
    parameter int          MAX_WORDS    = 4096,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              prog_done,
    output logic              frame_err
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int WCNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rx_sync1_q, rx_sync2_q;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         word_q, word_d;
    logic                wr_pend_q, wr_pend_d;
    logic [WCNT_W-1:0]   count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                prog_done_q, prog_done_d;
    logic                frame_err_q, frame_err_d;
    logic                rx_s;
    logic                stop_bad;
    logic [31:0]         word_ins;

    assign rx_s = rx_sync2_q;

    // The byte just received replaces the lane selected by byte_idx; other lanes keep their contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_ins[8*gi +: 8] = (byte_idx_q == 2'(gi)) ? shift_q : word_q[8*gi +: 8];
        end
    endgenerate

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;
    // Drop the byte if the stop bit is low or the earlier parity check failed.
    assign stop_bad = !rx_s || par_err_q;
`else
    // Drop the byte if the stop bit is low.
    assign stop_bad = !rx_s;
`endif

    // Compute the next FSM state, the byte and word assembly, and the memory-write strobe.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        wr_pend_d   = 1'b0;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        prog_done_d = prog_done_q;
        frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                // Recheck the line at mid-bit so that a short glitch does not start a byte.
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                // Record the parity result and wait for the stop bit, so the FSM does not
                // return to IDLE while the line may still be low.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    par_err_d = (rx_s != ^shift_q);
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (stop_bad) begin
                        frame_err_d = 1'b1;
                    end else if (byte_idx_q == 2'd3) begin
                        byte_idx_d = '0;
                        if (word_ins == END_WORD) begin
                            state_d     = DONE;
                            prog_done_d = 1'b1;
                        end else begin
                            word_d    = word_ins;
                            wr_pend_d = 1'b1;
                        end
                    end else begin
                        word_d     = word_ins;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The write is issued one cycle after the word completes. The last permitted
        // word ends loading, so the address never wraps.
        if (wr_pend_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = count_q[ADDR_W-1:0];
            mem_wdata_d = word_q;
            count_d     = count_q + 1'b1;
            if (count_q == LAST_WORD) begin
                prog_done_d = 1'b1;
                state_d     = DONE;
            end
        end
    end

    // Hold all state in registers; the input synchroniser resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            wr_pend_q   <= 1'b0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            prog_done_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_sync1_q  <= rx_i;
            rx_sync2_q  <= rx_sync1_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            wr_pend_q   <= wr_pend_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            prog_done_q <= prog_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign prog_done = prog_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed bench for uart_prog_loader with CLKS_PER_BIT=8,
// ADDR_W=4 and MAX_WORDS=4. The bench drives serial frames on rx_i and a
// monitor records every write strobe and frame_err cycle.
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;

    logic          clk;
    logic          rst_n;
    logic          rx_i;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          prog_done;
    logic          frame_err;

    int            n_cmp;
    int            n_err;
    int            n_wr;
    int            n_fe;
    logic [31:0]   wr_addr [0:15];
    logic [31:0]   wr_data [0:15];

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .MAX_WORDS    (4),
        .END_WORD     (32'h0000_0FFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .prog_done (prog_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each write strobe and each frame_err cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (n_wr < 16) begin
                wr_addr[n_wr] = 32'(mem_addr);
                wr_data[n_wr] = mem_wdata;
            end
            $display("write %0d: addr=%0d data=%h", n_wr, mem_addr, mem_wdata);
            n_wr = n_wr + 1;
        end
        if (frame_err === 1'b1) begin
            $display("frame_err pulse");
            n_fe = n_fe + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_wr = 0;
        n_fe = 0;
        repeat (4) @(negedge clk);
    endtask

    // Send one frame: start bit, 8 data bits LSB first, optional parity bit, stop bit, then idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_i = (^b) ^ bad_par;
        repeat (CPB) @(negedge clk);
`else
        if (bad_par) rx_i = 1'b1;
`endif
        rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        $display("sent byte %h stop=%0b", b, stop_bit);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_wr  = 0;
        n_fe  = 0;
        rx_i  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, sampled while reset is still asserted.
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_prog_done", 32'(prog_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);

        // Four bytes make one little-endian word at address 0.
        do_reset();
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t1_nwr",       32'(n_wr),      32'd1);
        chk("t1_addr",      wr_addr[0],     32'd0);
        chk("t1_data",      wr_data[0],     32'h1234_5678);
        chk("t1_hold_data", mem_wdata,      32'h1234_5678);
        chk("t1_prog_done", 32'(prog_done), 32'd0);

        // The terminator word ends loading without being written.
        do_reset();
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_nwr",       32'(n_wr),      32'd2);
        chk("t2_addr0",     wr_addr[0],     32'd0);
        chk("t2_data0",     wr_data[0],     32'h1111_1111);
        chk("t2_addr1",     wr_addr[1],     32'd1);
        chk("t2_data1",     wr_data[1],     32'h2222_2222);
        chk("t2_prog_done", 32'(prog_done), 32'd1);

        // A 3-clock low glitch is a false start: no error, no byte.
        do_reset();
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
        chk("t3_glitch_fe",  32'(n_fe), 32'd0);
        chk("t3_glitch_nwr", 32'(n_wr), 32'd0);
        send_word(32'hD4C3_B2A1);
        repeat (10) @(negedge clk);
        chk("t3_nwr",  32'(n_wr),  32'd1);
        chk("t3_data", wr_data[0], 32'hD4C3_B2A1);

        // A bad stop bit drops the byte and pulses frame_err once.
        do_reset();
        send_byte(8'hAA, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("t4_fe", 32'(n_fe), 32'd1);
        send_word(32'h0403_0201);
        repeat (10) @(negedge clk);
        chk("t4_nwr",  32'(n_wr),  32'd1);
        chk("t4_addr", wr_addr[0], 32'd0);
        chk("t4_data", wr_data[0], 32'h0403_0201);

        // The fourth write reaches MAX_WORDS and completes loading; later bytes are ignored.
        do_reset();
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0000);
        send_word(32'hCAFE_F00D);
        send_word(32'h0BAD_C0DE);
        repeat (10) @(negedge clk);
        chk("t5_nwr",       32'(n_wr),      32'd4);
        chk("t5_addr3",     wr_addr[3],     32'd3);
        chk("t5_data3",     wr_data[3],     32'h0BAD_C0DE);
        chk("t5_prog_done", 32'(prog_done), 32'd1);
        send_word(32'h1234_5678);
        repeat (10) @(negedge clk);
        chk("t5_nwr_after", 32'(n_wr), 32'd4);

        // Reset after two bytes discards the partial word.
        do_reset();
        send_byte(8'h99, 1'b1, 1'b0);
        send_byte(8'h88, 1'b1, 1'b0);
        do_reset();
        send_word(32'h1122_3344);
        repeat (10) @(negedge clk);
        chk("t6_nwr",  32'(n_wr),  32'd1);
        chk("t6_addr", wr_addr[0], 32'd0);
        chk("t6_data", wr_data[0], 32'h1122_3344);

`ifdef UART_PARITY_EN
        // A wrong parity bit drops the byte and pulses frame_err.
        do_reset();
        send_byte(8'h5A, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("t7_par_fe", 32'(n_fe), 32'd1);
        send_word(32'hA5A5_0001);
        repeat (10) @(negedge clk);
        chk("t7_data", wr_data[0], 32'hA5A5_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
